native_axi4_master: RTL and testbench

Initiator-side bridge between the PicoRV32-style native memory port (valid/ready, addr, wdata, wstrb, instr) and an AXI4-lite responder such as the testbench/FPGA memory model. It sequences one transaction at a time through independent AW/W/B and AR/R channels, uses registered AXI outputs, and aborts with an error flag if the responder stalls past a programmable timeout.

---
 rtl/native_axi4_master_if.sv | 67 ++++++
 rtl/native_axi4_master.sv | 206 ++++++++++++++++++++
 tb/tb_native_axi4_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/native_axi4_master_if.sv
// ============================================================================
// Module   : native_axi4_master_if
// Brief    : Native memory request port plus AXI4-lite initiator channels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface native_axi4_master_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        req_instr;
   logic [31:0] req_rdata;
   logic        req_err;

   logic        m_axi_awvalid;
   logic        m_axi_awready;
   logic [31:0] m_axi_awaddr;
   logic [2:0]  m_axi_awprot;
   logic        m_axi_wvalid;
   logic        m_axi_wready;
   logic [31:0] m_axi_wdata;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid;
   logic        m_axi_bready;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [31:0] m_axi_araddr;
   logic [2:0]  m_axi_arprot;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [31:0] m_axi_rdata;

   modport master (
      input  req_valid, req_addr, req_wdata, req_wstrb, req_instr,
      output req_ready, req_rdata, req_err,
      output m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
      input  m_axi_awready,
      output m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
      input  m_axi_wready,
      input  m_axi_bvalid,
      output m_axi_bready,
      output m_axi_arvalid, m_axi_araddr, m_axi_arprot,
      input  m_axi_arready,
      input  m_axi_rvalid, m_axi_rdata,
      output m_axi_rready
   );

   modport slave (
      output req_valid, req_addr, req_wdata, req_wstrb, req_instr,
      input  req_ready, req_rdata, req_err,
      input  m_axi_awvalid, m_axi_awaddr, m_axi_awprot,
      output m_axi_awready,
      input  m_axi_wvalid, m_axi_wdata, m_axi_wstrb,
      output m_axi_wready,
      output m_axi_bvalid,
      input  m_axi_bready,
      input  m_axi_arvalid, m_axi_araddr, m_axi_arprot,
      output m_axi_arready,
      output m_axi_rvalid, m_axi_rdata,
      input  m_axi_rready
   );
endinterface

`default_nettype wire

// File: rtl/native_axi4_master.sv
// ============================================================================
// Module   : native_axi4_master
// Brief    : Native valid/ready memory port to AXI4-lite initiator bridge,
//            one transaction at a time, with a responder-stall timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module native_axi4_master #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   native_axi4_master_if.master   bus
);

   localparam int c_cnt_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [c_cnt_w-1:0] c_tmo_last =
      (TIMEOUT_CYCLES > 0) ? c_cnt_w'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RADDR = 3'd1,
      S_RDATA = 3'd2,
      S_WADDR = 3'd3,
      S_WRESP = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t              r_state,   w_state_nxt;
   logic [c_cnt_w-1:0]  r_cnt,     w_cnt_nxt;
   logic                r_awvalid, w_awvalid_nxt;
   logic                r_wvalid,  w_wvalid_nxt;
   logic                r_bready,  w_bready_nxt;
   logic                r_arvalid, w_arvalid_nxt;
   logic                r_rready,  w_rready_nxt;
   logic                r_req_ready, w_req_ready_nxt;
   logic                r_req_err, w_req_err_nxt;
   logic [31:0]         r_rdata,   w_rdata_nxt;
   logic [31:0]         r_addr,    w_addr_nxt;
   logic [31:0]         r_wdata,   w_wdata_nxt;
   logic [3:0]          r_wstrb,   w_wstrb_nxt;
   logic                r_instr,   w_instr_nxt;

   logic                w_expire;
   logic                w_busy;
   logic                w_leave;
   logic [c_cnt_w-1:0]  w_cnt_inc;

   // Expiry fires on the edge at which the busy-cycle count would reach the limit.
   assign w_expire  = (TIMEOUT_CYCLES > 0) && (r_cnt == c_tmo_last);
   assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + c_cnt_w'(1);

   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_awvalid_nxt   = r_awvalid;
      w_wvalid_nxt    = r_wvalid;
      w_bready_nxt    = r_bready;
      w_arvalid_nxt   = r_arvalid;
      w_rready_nxt    = r_rready;
      w_req_ready_nxt = 1'b0;
      w_req_err_nxt   = 1'b0;
      w_rdata_nxt     = r_rdata;
      w_addr_nxt      = r_addr;
      w_wdata_nxt     = r_wdata;
      w_wstrb_nxt     = r_wstrb;
      w_instr_nxt     = r_instr;
      w_busy          = 1'b0;
      w_leave         = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (bus.req_valid) begin
               w_addr_nxt  = bus.req_addr;
               w_wdata_nxt = bus.req_wdata;
               w_wstrb_nxt = bus.req_wstrb;
               w_instr_nxt = bus.req_instr;
               if (bus.req_wstrb == 4'b0000) begin
                  w_state_nxt   = S_RADDR;
                  w_arvalid_nxt = 1'b1;
               end else begin
                  w_state_nxt   = S_WADDR;
                  w_awvalid_nxt = 1'b1;
                  w_wvalid_nxt  = 1'b1;
               end
            end
         end
         S_RADDR: begin
            w_busy    = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (bus.m_axi_arready) begin
               w_leave       = 1'b1;
               w_arvalid_nxt = 1'b0;
               w_rready_nxt  = 1'b1;
               w_state_nxt   = S_RDATA;
            end
         end
         S_RDATA: begin
            w_busy    = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (bus.m_axi_rvalid) begin
               w_leave         = 1'b1;
               w_rready_nxt    = 1'b0;
               w_rdata_nxt     = bus.m_axi_rdata;
               w_req_ready_nxt = 1'b1;
               w_state_nxt     = S_DONE;
            end
         end
         S_WADDR: begin
            w_busy        = 1'b1;
            w_cnt_nxt     = w_cnt_inc;
            // AW and W retire independently; a channel already retired reads as done.
            w_awvalid_nxt = r_awvalid && !bus.m_axi_awready;
            w_wvalid_nxt  = r_wvalid && !bus.m_axi_wready;
            if (!w_awvalid_nxt && !w_wvalid_nxt) begin
               w_leave      = 1'b1;
               w_bready_nxt = 1'b1;
               w_state_nxt  = S_WRESP;
            end
         end
         S_WRESP: begin
            w_busy    = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if (bus.m_axi_bvalid) begin
               w_leave         = 1'b1;
               w_bready_nxt    = 1'b0;
               w_req_ready_nxt = 1'b1;
               w_state_nxt     = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // A final handshake on the expiry edge takes priority over the abort.
      if (w_busy && !w_leave && w_expire) begin
         w_state_nxt     = S_DONE;
         w_awvalid_nxt   = 1'b0;
         w_wvalid_nxt    = 1'b0;
         w_bready_nxt    = 1'b0;
         w_arvalid_nxt   = 1'b0;
         w_rready_nxt    = 1'b0;
         w_rdata_nxt     = 32'hFFFF_FFFF;
         w_req_err_nxt   = 1'b1;
         w_req_ready_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_arvalid   <= 1'b0;
         r_rready    <= 1'b0;
         r_req_ready <= 1'b0;
         r_req_err   <= 1'b0;
         r_rdata     <= '0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_wstrb     <= '0;
         r_instr     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_awvalid   <= w_awvalid_nxt;
         r_wvalid    <= w_wvalid_nxt;
         r_bready    <= w_bready_nxt;
         r_arvalid   <= w_arvalid_nxt;
         r_rready    <= w_rready_nxt;
         r_req_ready <= w_req_ready_nxt;
         r_req_err   <= w_req_err_nxt;
         r_rdata     <= w_rdata_nxt;
         r_addr      <= w_addr_nxt;
         r_wdata     <= w_wdata_nxt;
         r_wstrb     <= w_wstrb_nxt;
         r_instr     <= w_instr_nxt;
      end
   end

   assign bus.req_ready     = r_req_ready;
   assign bus.req_err       = r_req_err;
   assign bus.req_rdata     = r_rdata;
   assign bus.m_axi_awvalid = r_awvalid;
   assign bus.m_axi_awaddr  = r_addr;
   assign bus.m_axi_awprot  = 3'b000;
   assign bus.m_axi_wvalid  = r_wvalid;
   assign bus.m_axi_wdata   = r_wdata;
   assign bus.m_axi_wstrb   = r_wstrb;
   assign bus.m_axi_bready  = r_bready;
   assign bus.m_axi_arvalid = r_arvalid;
   assign bus.m_axi_araddr  = r_addr;
   assign bus.m_axi_arprot  = {r_instr, 2'b00};
   assign bus.m_axi_rready  = r_rready;

endmodule

`default_nettype wire

// File: tb/tb_native_axi4_master.sv
// ============================================================================
// Module   : tb_native_axi4_master
// Brief    : Scoreboard bench for native_axi4_master with a wait-state
//            programmable AXI4-lite responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_native_axi4_master;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   native_axi4_master_if bus();

   native_axi4_master #(.TIMEOUT_CYCLES(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          t0;
   } sb_t;

   sb_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // responder configuration: wait cycles per channel, -1 = never respond
   int          cfg_ar = 0, cfg_r = 0, cfg_aw = 0, cfg_w = 0, cfg_b = 0;
   logic [31:0] cfg_rdata = '0;
   int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   int          n_ar = 0, n_r = 0, n_aw = 0, n_w = 0, n_b = 0;

   // expected request fields, seen on the AXI side while valid
   logic [31:0] cur_addr = '0, cur_wdata = '0;
   logic [3:0]  cur_wstrb = '0;
   logic        cur_instr = 1'b0;
   int          ar_hi = 0, aw_hi = 0;
   logic        aw_alone = 1'b0;
   logic        prev_rdy = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // AXI4-lite responder
   always @(negedge clk) begin
      if (rst) begin
         bus.m_axi_arready = 1'b0; bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
         bus.m_axi_rvalid  = 1'b0; bus.m_axi_bvalid  = 1'b0; bus.m_axi_rdata  = '0;
         ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
         bus.m_axi_arready = bus.m_axi_arvalid && cfg_ar >= 0 && ar_cnt >= cfg_ar;
         if (!bus.m_axi_arvalid) ar_cnt = 0; else if (!bus.m_axi_arready) ar_cnt++;
         bus.m_axi_awready = bus.m_axi_awvalid && cfg_aw >= 0 && aw_cnt >= cfg_aw;
         if (!bus.m_axi_awvalid) aw_cnt = 0; else if (!bus.m_axi_awready) aw_cnt++;
         bus.m_axi_wready = bus.m_axi_wvalid && cfg_w >= 0 && w_cnt >= cfg_w;
         if (!bus.m_axi_wvalid) w_cnt = 0; else if (!bus.m_axi_wready) w_cnt++;
         bus.m_axi_rvalid = bus.m_axi_rready && cfg_r >= 0 && r_cnt >= cfg_r;
         bus.m_axi_rdata  = cfg_rdata;
         if (!bus.m_axi_rready) r_cnt = 0; else if (!bus.m_axi_rvalid) r_cnt++;
         bus.m_axi_bvalid = bus.m_axi_bready && cfg_b >= 0 && b_cnt >= cfg_b;
         if (!bus.m_axi_bready) b_cnt = 0; else if (!bus.m_axi_bvalid) b_cnt++;
         // both sides stable until the next rising edge, so these handshakes complete there
         if (bus.m_axi_arvalid && bus.m_axi_arready) n_ar++;
         if (bus.m_axi_awvalid && bus.m_axi_awready) n_aw++;
         if (bus.m_axi_wvalid  && bus.m_axi_wready)  n_w++;
         if (bus.m_axi_rvalid  && bus.m_axi_rready)  n_r++;
         if (bus.m_axi_bvalid  && bus.m_axi_bready)  n_b++;
      end
   end

   // monitor: AXI field integrity and native completions against the scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.m_axi_arvalid) begin
            ar_hi++;
            check("araddr", bus.m_axi_araddr, cur_addr);
            check("arprot", 32'(bus.m_axi_arprot), 32'({cur_instr, 2'b00}));
         end
         if (bus.m_axi_awvalid) begin
            aw_hi++;
            check("awaddr", bus.m_axi_awaddr, cur_addr);
            check("awprot", 32'(bus.m_axi_awprot), 32'd0);
         end
         if (bus.m_axi_wvalid) begin
            check("wdata", bus.m_axi_wdata, cur_wdata);
            check("wstrb", 32'(bus.m_axi_wstrb), 32'(cur_wstrb));
         end
         if (bus.m_axi_awvalid && !bus.m_axi_wvalid) aw_alone = 1'b1;
         if (bus.m_axi_bready)
            check("bready_excl", 32'(bus.m_axi_awvalid | bus.m_axi_wvalid), 32'd0);
         if (bus.req_ready) begin
            check("rdy_pulse", 32'(prev_rdy), 32'd0);
            if (sb_q.size() == 0) begin
               check("spurious_rdy", 32'd1, 32'd0);
            end else begin
               sb_t e;
               e = sb_q.pop_front();
               check("req_rdata", bus.req_rdata, e.rdata);
               check("req_err", 32'(bus.req_err), 32'(e.err));
               check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
         end else if (prev_rdy) begin
            check("err_pulse", 32'(bus.req_err), 32'd0);
         end
         prev_rdy = bus.req_ready;
      end else begin
         prev_rdy = 1'b0;
      end
   end

   task automatic set_cfg(input int ar, input int r, input int aw, input int w, input int b,
                          input logic [31:0] rd);
      cfg_ar = ar; cfg_r = r; cfg_aw = aw; cfg_w = w; cfg_b = b; cfg_rdata = rd;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic ins, input logic [31:0] erd, input logic eerr, input int elat);
      sb_t e;
      @(negedge clk);
      cur_addr = a; cur_wdata = wd; cur_wstrb = ws; cur_instr = ins;
      bus.req_addr = a; bus.req_wdata = wd; bus.req_wstrb = ws; bus.req_instr = ins;
      bus.req_valid = 1'b1;
      e.rdata = erd; e.err = eerr; e.lat = elat; e.t0 = cyc;
      sb_q.push_back(e);
   endtask

   task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input logic ins, input logic [31:0] erd, input logic eerr, input int elat);
      int n;
      drive(a, wd, ws, ins, erd, eerr, elat);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.req_ready && n < 60);
      if (!bus.req_ready) begin
         check("req_timeout", 32'd0, 32'd1);
         sb_q.delete();
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_arvalid"}, 32'(bus.m_axi_arvalid), 32'd0);
      check({tag, "_awvalid"}, 32'(bus.m_axi_awvalid), 32'd0);
      check({tag, "_wvalid"},  32'(bus.m_axi_wvalid),  32'd0);
      check({tag, "_rready"},  32'(bus.m_axi_rready),  32'd0);
      check({tag, "_bready"},  32'(bus.m_axi_bready),  32'd0);
      check({tag, "_req_rdy"}, 32'(bus.req_ready),     32'd0);
      check({tag, "_req_err"}, 32'(bus.req_err),       32'd0);
      check({tag, "_rdata"},   bus.req_rdata,          32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s_ar, s_aw, s_w, s_r, s_b, n;
      bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus.req_wstrb = '0; bus.req_instr = 1'b0;
      #1 rst = 1'b1;
      #11;
      check_idle_outputs("reset");
      check("reset_araddr", bus.m_axi_araddr, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // read with instruction fetch and two AR wait states
      set_cfg(2, 0, 0, 0, 0, 32'h1234_5678);
      ar_hi = 0;
      do_req(32'h0000_0010, 32'h0, 4'b0000, 1'b1, 32'h1234_5678, 1'b0, 5);
      check("rd_ar_cycles", 32'(ar_hi), 32'd3);

      // write with W accepted three cycles before AW
      set_cfg(0, 0, 3, 0, 0, 32'hDEAD_0000);
      aw_hi = 0; aw_alone = 1'b0;
      do_req(32'h0000_0020, 32'hA5A5_A5A5, 4'b0101, 1'b0, 32'h1234_5678, 1'b0, 6);
      check("wr_w_first", 32'(aw_alone), 32'd1);
      check("wr_aw_cycles", 32'(aw_hi), 32'd4);

      // back-to-back read / write / read
      s_ar = n_ar; s_aw = n_aw; s_w = n_w; s_r = n_r; s_b = n_b;
      set_cfg(0, 0, 0, 0, 0, 32'hCAFE_F00D);
      do_req(32'h0000_0100, 32'h0, 4'b0000, 1'b0, 32'hCAFE_F00D, 1'b0, 3);
      set_cfg(0, 0, 0, 0, 0, 32'h5555_AAAA);
      do_req(32'h0000_0104, 32'h0F0F_0F0F, 4'b1111, 1'b0, 32'hCAFE_F00D, 1'b0, 3);
      set_cfg(0, 0, 0, 0, 0, 32'h0BAD_BEEF);
      do_req(32'h0000_0108, 32'h0, 4'b0000, 1'b1, 32'h0BAD_BEEF, 1'b0, 3);
      check("b2b_ar", 32'(n_ar - s_ar), 32'd2);
      check("b2b_r",  32'(n_r - s_r),   32'd2);
      check("b2b_aw", 32'(n_aw - s_aw), 32'd1);
      check("b2b_w",  32'(n_w - s_w),   32'd1);
      check("b2b_b",  32'(n_b - s_b),   32'd1);

      // AR never accepted: abort after eight busy cycles
      set_cfg(-1, 0, 0, 0, 0, 32'h0);
      ar_hi = 0;
      do_req(32'h0000_0200, 32'h0, 4'b0000, 1'b0, 32'hFFFF_FFFF, 1'b1, 9);
      check("tmo_ar_cycles", 32'(ar_hi), 32'd8);
      set_cfg(0, 0, 0, 0, 0, 32'h1111_2222);
      do_req(32'h0000_0204, 32'h0, 4'b0000, 1'b0, 32'h1111_2222, 1'b0, 3);

      // B handshake on the expiry edge completes normally; one cycle later aborts
      s_b = n_b;
      set_cfg(0, 0, 0, 0, 6, 32'h0);
      do_req(32'h0000_0300, 32'h7777_8888, 4'b0011, 1'b0, 32'h1111_2222, 1'b0, 9);
      check("expiry_b_hs", 32'(n_b - s_b), 32'd1);
      set_cfg(0, 0, 0, 0, 7, 32'h0);
      do_req(32'h0000_0304, 32'h9999_0000, 4'b1000, 1'b0, 32'hFFFF_FFFF, 1'b1, 9);
      check("abort_b_hs", 32'(n_b - s_b), 32'd1);

      // reset while waiting in WRESP
      set_cfg(0, 0, 0, 0, -1, 32'h0);
      drive(32'h0000_0400, 32'h1357_9BDF, 4'b1111, 1'b0, 32'h0, 1'b0, 0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.m_axi_bready && n < 20);
      check("wresp_reached", 32'(bus.m_axi_bready), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_idle_outputs("midrst");
      sb_q.delete();
      bus.req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 32'h3333_4444);
      do_req(32'h0000_0500, 32'h0, 4'b0000, 1'b0, 32'h3333_4444, 1'b0, 3);

      repeat (3) @(negedge clk);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
